// File: rtl/rf_mp.sv
// Multi-port register file: two bypassed combinational read ports, two write ports,
// and a per-register busy scoreboard with a running count for RAW hazard detection.
module rf_mp #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wen0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            wen1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1,
  output logic            pend0,
  output logic            pend1,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [AW:0]     busy_cnt,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int NREG = 1 << AW;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  // No handshakes: every write and reserve presented at a rising edge is accepted.
  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            we0, we1, rsv;

  assign we0 = wen0   && (waddr0   != '0);
  assign we1 = wen1   && (waddr1   != '0);
  assign rsv = rsv_en && (rsv_addr != '0);

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
    end
  end

  // A reserve overrides a same-cycle clear: the new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[waddr0] = 1'b0;
    if (we1) busy_d[waddr1] = 1'b0;
    if (rsv) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < NREG; i++) begin
      if (busy_d[i] && !busy_q[i])      cnt_d = cnt_d + CNT_ONE;
      else if (!busy_d[i] && busy_q[i]) cnt_d = cnt_d - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [AW-1:0]   ra   [2];
  logic [XLEN-1:0] rd_c [2];
  logic            pd_c [2];

  assign ra[0] = raddr0;
  assign ra[1] = raddr1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic h0, h1;
      h0 = BYPASS && we0 && (waddr0 == ra[p]);
      h1 = BYPASS && we1 && (waddr1 == ra[p]);
      rd_c[p] = '0;
      pd_c[p] = 1'b0;
      if (ra[p] != '0) begin
        if (h1)      rd_c[p] = wdata1;
        else if (h0) rd_c[p] = wdata0;
        else         rd_c[p] = mem_q[ra[p]];
        pd_c[p] = busy_q[ra[p]] && !(h0 || h1);
      end
    end
  end

  assign rdata0   = rd_c[0];
  assign rdata1   = rd_c[1];
  assign pend0    = pd_c[0];
  assign pend1    = pd_c[1];
  assign busy_cnt = cnt_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule
